// File: rtl/layer_pipe_pkg.sv
// Shared types and helpers for the layer pipeline controller.
package layer_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Population count over a zero-extended valid vector (up to 32 stages).
  function automatic int unsigned popcount(input logic [31:0] vec);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/layer_pipe_ctrl_pipe_stage_vld.sv
// One stage valid bit with its bubble-collapsing ready and load-enable logic.
module pipe_stage_vld
  import layer_pipe_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic up_valid_i,
  input  logic rdy_dn_i,
  output logic rdy_o,
  output logic en_o,
  output logic v_o,
  output logic v_d_o
);

  logic v_q;
  logic v_d;

  always_comb begin
    rdy_o = !v_q | rdy_dn_i;
    en_o  = up_valid_i & rdy_o;
    v_d   = v_q;
    if (en_o) begin
      v_d = 1'b1;
    end else if (v_q & rdy_dn_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  assign v_o   = v_q;
  assign v_d_o = v_d;

endmodule

// File: rtl/layer_pipe_ctrl.sv
// Valid/ready controller for a chain of registered LogicNets layers: stage
// enables, flush/drain sequencing, occupancy and a saturating sample counter.
module layer_pipe_ctrl
  import layer_pipe_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  parameter  int CNT_W      = 16,
  localparam int OCC_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [OCC_W-1:0]      occupancy_o,
  output logic [CNT_W-1:0]      sample_cnt_o,
  output logic                  busy_o,
  output logic                  drain_done_o
);

  state_e             state_q;
  logic [OCC_W-1:0]   occ_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               drain_done_q;
  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] v_d;
  logic               run;

  assign run = (state_q == RUN);

  // Each stage keeps its own ready wire so the chain is a set of distinct
  // signals rather than one self-referencing vector.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    logic rdy_w;
    logic en_w;
    logic up_w;
    logic dn_w;

    if (k == 0) begin : g_first
      assign up_w = in_valid_i & run;
    end else begin : g_inner
      assign up_w = v[k-1];
    end

    if (k == NUM_STAGES - 1) begin : g_last
      assign dn_w = out_ready_i;
    end else begin : g_mid
      assign dn_w = g_stg[k+1].rdy_w;
    end

    pipe_stage_vld u_vld (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .up_valid_i (up_w),
      .rdy_dn_i   (dn_w),
      .rdy_o      (rdy_w),
      .en_o       (en_w),
      .v_o        (v[k]),
      .v_d_o      (v_d[k])
    );

    assign stage_en_o[k] = en_w;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      cnt_q        <= '0;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE:    if (enable_i) state_q <= RUN;
        RUN:     if (flush_i || !enable_i) state_q <= DRAIN;
        DRAIN: begin
          if (occ_q == '0 && stage_en_o == '0) begin
            state_q      <= IDLE;
            drain_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      occ_q <= OCC_W'(popcount(32'(v_d)));
      if (out_valid_o && out_ready_i && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready_o   = g_stg[0].rdy_w & run;
  assign out_valid_o  = v[NUM_STAGES-1];
  assign occupancy_o  = occ_q;
  assign sample_cnt_o = cnt_q;
  assign busy_o       = (state_q != IDLE) || (occ_q != '0);
  assign drain_done_o = drain_done_q;

endmodule

// File: tb/tb_layer_pipe_ctrl.sv
// Self-checking bench: directed phases plus random traffic against a slot model.
module tb_layer_pipe_ctrl;

  localparam int N = 4;

  logic clk;
  logic rst, enable, flush, in_valid, out_ready;
  logic in_ready, out_valid, busy, drain_done;
  logic [N-1:0] stage_en;
  logic [2:0] occupancy;
  logic [15:0] sample_cnt;
  logic in_ready_b, out_valid_b, busy_b, drain_done_b;
  logic [N-1:0] stage_en_b;
  logic [2:0] occupancy_b;
  logic [3:0] sample_cnt_b;

  layer_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .stage_en_o(stage_en), .occupancy_o(occupancy),
    .sample_cnt_o(sample_cnt), .busy_o(busy), .drain_done_o(drain_done));

  layer_pipe_ctrl #(.NUM_STAGES(N), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .out_valid_o(out_valid_b),
    .out_ready_i(out_ready), .stage_en_o(stage_en_b), .occupancy_o(occupancy_b),
    .sample_cnt_o(sample_cnt_b), .busy_o(busy_b), .drain_done_o(drain_done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: which pipeline slots hold a sample, controller mode, results delivered.
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
  bit s[N];
  bit ns[N];
  bit leave[N];
  int mode;
  int cnt;
  bit dd;
  bit model_ok = 0;
  bit dest_ok, exp_in_ready, fire;
  logic [N-1:0] exp_en;
  int occ;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) s[k] = 0;
      mode = M_IDLE; cnt = 0; dd = 0; model_ok = 1;
    end else if (model_ok) begin
      // A sample leaves its slot if the slot ahead is (or becomes) free.
      dest_ok = out_ready;
      for (int k = N - 1; k >= 0; k--) begin
        leave[k] = s[k] && dest_ok;
        dest_ok  = !s[k] || leave[k];
      end
      exp_in_ready = (mode == M_RUN) && dest_ok;
      exp_en = '0;
      exp_en[0] = in_valid && exp_in_ready;
      for (int k = 1; k < N; k++) exp_en[k] = leave[k-1];
      occ = 0;
      for (int k = 0; k < N; k++) occ += int'(s[k]);
      fire = s[N-1] && out_ready;

      chk("in_ready", int'(in_ready), int'(exp_in_ready));
      chk("out_valid", int'(out_valid), int'(s[N-1]));
      chk("stage_en", int'(stage_en), int'(exp_en));
      chk("occupancy", int'(occupancy), occ);
      chk("sample_cnt", int'(sample_cnt), cnt);
      chk("busy", int'(busy), int'(mode != M_IDLE || occ != 0));
      chk("drain_done", int'(drain_done), int'(dd));
      chk("sat_cnt", int'(sample_cnt_b), (cnt > 15) ? 15 : cnt);
      chk("sat_stage_en", int'(stage_en_b), int'(exp_en));

      for (int k = 0; k < N; k++)
        ns[k] = exp_en[k] ? 1'b1 : (leave[k] ? 1'b0 : s[k]);
      for (int k = 0; k < N; k++) s[k] = ns[k];
      if (fire) cnt++;
      dd = 0;
      case (mode)
        M_IDLE:  if (enable) mode = M_RUN;
        M_RUN:   if (flush || !enable) mode = M_DRAIN;
        default: if (occ == 0 && exp_en == '0) begin mode = M_IDLE; dd = 1; end
      endcase
    end
  end

  // Event counters for the directed phases.
  int cyc = 0, acc_cnt, out_cnt, dd_cnt, first_acc, first_out, last_out, occ_peak;

  task automatic clr_mon();
    acc_cnt = 0; out_cnt = 0; dd_cnt = 0;
    first_acc = -1; first_out = -1; last_out = -1; occ_peak = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_cnt++;
      end
      if (drain_done) dd_cnt++;
      if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_until(input int n);
    int i;
    in_valid = 1;
    for (i = 0; i < 60 && acc_cnt < n; i++) step();
    in_valid = 0;
    if (acc_cnt < n) chk("feed_timeout", acc_cnt, n);
  endtask

  task automatic wait_idle(input bit need_state_idle);
    int i;
    for (i = 0; i < 60 && (occupancy != 0 || (need_state_idle && busy)); i++) step();
    if (i == 60) chk("drain_timeout", int'(occupancy), 0);
  endtask

  initial begin
    rst = 0; enable = 0; flush = 0; in_valid = 0; out_ready = 0;
    clr_mon();
    step(); step();
    chk("reset_occ", int'(occupancy), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst = 1;

    // Streaming
    enable = 1; out_ready = 1;
    step();
    clr_mon();
    feed_until(10);
    wait_idle(0);
    step();
    chk("stream_accepts", acc_cnt, 10);
    chk("stream_results", out_cnt, 10);
    chk("stream_latency", first_out - first_acc, 4);
    chk("stream_consecutive", last_out - first_out, 9);
    chk("stream_sample_cnt", int'(sample_cnt), 10);
    chk("stream_occ_peak", occ_peak, 4);

    // Backpressure
    clr_mon();
    out_ready = 0;
    feed_until(4);
    repeat (8) begin
      step();
      chk("bp_occ", int'(occupancy), 4);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_stage_en", int'(stage_en), 0);
    end
    out_ready = 1;
    wait_idle(0);
    step();
    chk("bp_results", out_cnt, 4);
    chk("bp_consecutive", last_out - first_out, 3);

    // Bubble collapse
    clr_mon();
    out_ready = 0;
    feed_until(2);
    repeat (4) step();
    chk("bubble_occ", int'(occupancy), 2);
    chk("bubble_out_valid", int'(out_valid), 1);
    chk("bubble_in_ready", int'(in_ready), 1);
    chk("bubble_stage_en", int'(stage_en), 0);
    out_ready = 1;
    wait_idle(0);

    // Flush with same-cycle input
    clr_mon();
    feed_until(3);
    in_valid = 1; flush = 1;
    step();
    in_valid = 0; flush = 0; enable = 0;
    wait_idle(1);
    repeat (3) step();
    chk("flush_accepts", acc_cnt, 4);
    chk("flush_results", out_cnt, 4);
    chk("flush_drain_done", dd_cnt, 1);
    chk("flush_busy", int'(busy), 0);

    // Reset mid-operation
    enable = 1; out_ready = 0;
    step();
    clr_mon();
    feed_until(3);
    step();
    chk("pre_reset_occ", int'(occupancy), 3);
    rst = 0;
    step();
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stage_en", int'(stage_en), 0);
    rst = 1;

    // Saturation of the narrow counter
    out_ready = 1;
    step();
    clr_mon();
    feed_until(20);
    wait_idle(0);
    repeat (3) step();
    chk("sat_wide_cnt", int'(sample_cnt), 20);
    chk("sat_narrow_cnt", int'(sample_cnt_b), 15);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 16) != 0;
      flush     = ($urandom % 24) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 600) != 0;
      step();
    end
    rst = 1; enable = 0; flush = 0; in_valid = 0; out_ready = 1;
    wait_idle(1);
    repeat (3) step();
    chk("final_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_pipe_ctrl.md
Name: layer_pipe_ctrl

Overview:
- Valid/ready pipeline controller for a chain of registered LogicNets layers, each layer a bank of combinational 6-in/2-out neuron LUTs.
- Owns one valid bit per stage and produces the per-stage register enables for the external activation registers between layers.
- Provides backpressure, flush/drain sequencing, an occupancy count and a classified-sample counter.
- Sits between the input feature capture and the classifier output port.

Parameters:
- NUM_STAGES, 4: number of registered layer stages (minimum 1).
- CNT_W, 16: width of the saturating sample counter.
- OCC_W, $clog2(NUM_STAGES+1): occupancy width (derived, not overridable).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-low reset.
- enable  in  1  level; allows the controller to accept samples.
- flush  in  1  one-cycle request to stop intake and drain.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  controller accepts the sample this cycle.
- out_valid  out  1  last stage holds a result (valid bit of stage NUM_STAGES-1).
- out_ready  in  1  downstream consumes the result.
- stage_en  out  NUM_STAGES  load enable for stage k's activation register.
- occupancy  out  OCC_W  count of stage valid bits set.
- sample_cnt  out  CNT_W  completed output handshakes, saturating.
- busy  out  1  state != IDLE or occupancy != 0.
- drain_done  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Reset (rst==0 at a clock edge), any state, mid-operation included:
  - Internal: all valid bits 0, state IDLE, sample_cnt 0.
  - Outputs: drain_done 0, out_valid 0, occupancy 0, busy 0, in_ready 0, stage_en all 0.
- States: IDLE, RUN, DRAIN.
  - IDLE->RUN when enable==1.
  - RUN->DRAIN when flush==1 or enable==0.
  - DRAIN->IDLE when occupancy==0 and no stage_en bit is asserted this cycle; drain_done pulses on that transition.
  - flush in IDLE or DRAIN is ignored.
- Stage readiness, combinational: rdy[NUM_STAGES]=out_ready; rdy[k]=!v[k] | rdy[k+1]. Full-throughput bubble-collapsing chain; no combinational path from in_valid to out_ready.
- in_ready = rdy[0] & (state==RUN). Uses the current state, so a sample offered in the cycle flush is raised is still accepted.
- Stage enables:
  - stage_en[0] = in_valid & in_ready.
  - stage_en[k] = v[k-1] & rdy[k], for k>0.
- Valid bit update:
  - v[k] is set when stage_en[k]==1.
  - v[k] is cleared when it is downstream-consumed without reload: v[k] & rdy[k+1] & !stage_en[k].
- Latency, no stall: a sample accepted at cycle t gives out_valid=1 at t+NUM_STAGES.
- Throughput: one sample per cycle while out_ready==1.
- Stall: out_ready==0 with the pipe full forces all stage_en to 0 and in_ready to 0. Contents hold indefinitely; no sample is lost or duplicated.
- occupancy: registered popcount of v, updated every cycle.
- sample_cnt: increments on out_valid & out_ready; holds at 2^CNT_W-1.
- DRAIN: in_ready=0 while stages keep advancing under out_ready; it never drops results.

Decomposition:
- Package layer_pipe_pkg: state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and a popcount function.
- One sub-module, pipe_stage_vld: a single valid bit with its rdy/en logic. It is instantiated NUM_STAGES times in a generate loop.
- The top module holds the FSM, occupancy and sample_cnt.

Test Plan:
- Streaming: NUM_STAGES=4, rst low 2 cycles, enable=1, in_valid=1 for 10 cycles, out_ready=1. Expect first out_valid 4 cycles after first accept, 10 consecutive results, sample_cnt=10, occupancy peaks at 4.
- Backpressure: out_ready=0 after 4 accepts. Expect occupancy=4, in_ready=0, stage_en=4'b0000 held 8 cycles. Then out_ready=1: 4 results in 4 consecutive cycles.
- Bubble collapse: fill 2 samples, drop in_valid, out_ready=0. Expect v=4'b1100 after 4 cycles and in_ready stays 1.
- Flush with same-cycle input: in_valid=1 and flush=1 in RUN with 3 in flight. Expect that sample accepted, DRAIN entered, 4 outputs, drain_done one cycle, state IDLE.
- Reset mid-operation: rst=0 with occupancy=3 and out_ready=0. Next cycle expect occupancy=0, out_valid=0, sample_cnt=0, busy=0.
- Saturation: CNT_W=4, 20 handshakes. Expect sample_cnt=15 held.
